// File: rtl/fpau_sched_pkg.sv
// fpau_sched_pkg -- shared definitions for the FP arithmetic-unit scheduler.
//   state_t      : scheduler FSM states
//   *_DEF        : default parameter values used by fpau_sched
package fpau_sched_pkg;

  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TAG_W_DEF   = 4;
  localparam int unsigned OP_W_DEF    = 6;
  localparam int unsigned TIMEOUT_DEF = 63;

  // Request payload carries op code, two 32-bit operands and the tag.
  localparam int unsigned OPND_BITS = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  function automatic int unsigned payload_width(input int unsigned op_w,
                                                input int unsigned tag_w);
    return op_w + OPND_BITS + tag_w;
  endfunction

endpackage

// File: rtl/fpau_req_fifo.sv
// fpau_req_fifo -- request queue for fpau_sched.
//   clk, rstn     : clock, asynchronous active-low reset (empties the queue)
//   push/push_data: write one entry (caller guarantees not full)
//   pop           : drop the head entry (caller guarantees not empty)
//   head          : current head entry
//   count         : occupancy, 0..DEPTH
module fpau_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 74
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fpau_sched.sv
// fpau_sched -- queues requests and issues them one at a time to an external
// arithmetic unit bank, waiting for completion or a timeout, then presents
// the result (in request order) on an output handshake.
//   clk, rstn                      : clock, asynchronous active-low reset
//   in_valid/in_ready              : request handshake
//   in_op, in_x1, in_x2, in_tag    : request payload
//   u_ready                        : one-cycle start pulse to the unit bank
//   u_op, u_x1, u_x2               : operands, held from issue until completion
//   u_valid, u_y32, u_y1           : unit bank completion and results
//   out_valid/out_ready            : result handshake
//   out_y32, out_y1, out_tag, out_err : result payload (out_err = timed out)
//   count                          : request queue occupancy
//   busy                           : scheduler not idle
module fpau_sched
  import fpau_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_op,
  input  logic [31:0]            in_x1,
  input  logic [31:0]            in_x2,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   u_ready,
  output logic [OP_W-1:0]        u_op,
  output logic [31:0]            u_x1,
  output logic [31:0]            u_x2,
  input  logic                   u_valid,
  input  logic [31:0]            u_y32,
  input  logic                   u_y1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_y32,
  output logic                   out_y1,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int unsigned PW    = payload_width(OP_W, TAG_W);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [TAG_W-1:0] tag_q;

  logic             push;
  logic             pop;
  logic [PW-1:0]    push_data;
  logic [PW-1:0]    head;
  logic [OP_W-1:0]  head_op;
  logic [31:0]      head_x1;
  logic [31:0]      head_x2;
  logic [TAG_W-1:0] head_tag;
  logic             done;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state == ST_IDLE) && (count != '0);
  assign push_data = {in_op, in_x1, in_x2, in_tag};
  assign {head_op, head_x1, head_x2, head_tag} = head;

  fpau_req_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // ISSUE and WAIT share one completion path; u_valid takes priority over
  // the timeout, and u_valid is only looked at while an op is in flight.
  // The timer also advances in ISSUE so WAIT's first cycle sees timer==1,
  // making a timeout land exactly TIMEOUT+1 cycles after the start pulse.
  always_comb begin
    done = 1'b0;
    if (state == ST_ISSUE) begin
      done = u_valid;
    end else if (state == ST_WAIT) begin
      done = u_valid || (timer == TMR_W'(TIMEOUT));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      timer     <= '0;
      tag_q     <= '0;
      u_ready   <= 1'b0;
      u_op      <= '0;
      u_x1      <= '0;
      u_x2      <= '0;
      out_valid <= 1'b0;
      out_y32   <= '0;
      out_y1    <= 1'b0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            state   <= ST_ISSUE;
            timer   <= '0;
            u_ready <= 1'b1;
            busy    <= 1'b1;
            u_op    <= head_op;
            u_x1    <= head_x1;
            u_x2    <= head_x2;
            tag_q   <= head_tag;
          end
        end

        ST_ISSUE, ST_WAIT: begin
          u_ready <= 1'b0;
          timer   <= timer + 1'b1;
          if (done) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            out_y32   <= u_valid ? u_y32 : '0;
            out_y1    <= u_valid ? u_y1 : 1'b0;
            out_err   <= !u_valid;
            out_tag   <= tag_q;
            u_op      <= '0;
            u_x1      <= '0;
            u_x2      <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_y32   <= '0;
            out_y1    <= 1'b0;
            out_err   <= 1'b0;
            out_tag   <= '0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpau_sched.sv
module tb_fpau_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned OP_W  = 6;
  localparam int          TO    = 63;
  localparam int          NEVER = 1000;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OP_W-1:0]   in_op = '0;
  logic [31:0]       in_x1 = '0;
  logic [31:0]       in_x2 = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              u_ready;
  logic [OP_W-1:0]   u_op;
  logic [31:0]       u_x1;
  logic [31:0]       u_x2;
  logic              u_valid = 1'b0;
  logic [31:0]       u_y32 = '0;
  logic              u_y1 = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_y32;
  logic              out_y1;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic [2:0]        count;
  logic              busy;

  fpau_sched #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .OP_W    (OP_W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .u_ready   (u_ready),
    .u_op      (u_op),
    .u_x1      (u_x1),
    .u_x2      (u_x2),
    .u_valid   (u_valid),
    .u_y32     (u_y32),
    .u_y1      (u_y1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y32   (out_y32),
    .out_y1    (out_y1),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A request plus the unit's scripted behaviour for it: respond d cycles
  // after the start pulse (d > TO means it never responds in time).
  typedef struct {
    logic [OP_W-1:0]  op;
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
    int               d;
    logic [31:0]      y32;
    logic             y1;
  } req_t;

  typedef struct {
    logic [31:0]      y32;
    logic             y1;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];
  int   due_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int bp_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int dmin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic req_t mk(input int op, input logic [31:0] x1, input logic [31:0] x2,
                              input int tag, input int d, input logic [31:0] y32, input logic y1);
    req_t r;
    r.op  = OP_W'(op);
    r.x1  = x1;
    r.x2  = x2;
    r.tag = TAG_W'(tag);
    r.d   = d;
    r.y32 = y32;
    r.y1  = y1;
    return r;
  endfunction

  function automatic req_t rand_req();
    int sel;
    int d;
    sel = $urandom_range(0, 15);
    if (sel == 0)      d = NEVER;
    else if (sel == 1) d = TO;
    else if (sel == 2) d = TO - 1;
    else if (sel == 3) d = 0;
    else               d = $urandom_range(1, 5);
    return mk($urandom_range(0, 63), $urandom, $urandom, $urandom_range(0, 15), d,
              $urandom, 1'($urandom));
  endfunction

  // Unit bank model: scripted latency per request, operand checks while an
  // op is in flight, and stray u_valid pulses whenever nothing is in flight.
  req_t cur;
  int   k = 0;
  bit   inflight = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      inflight = 0;
      u_valid  = 1'b0;
      u_y32    = '0;
      u_y1     = 1'b0;
    end else begin
      u_valid = 1'b0;
      u_y32   = $urandom;
      u_y1    = 1'($urandom);
      if (u_ready) begin
        chk("u_ready_pulse", {inflight, out_valid}, 0);
        if (req_q.size() == 0) begin
          chk("issue_unexpected", u_ready, 0);
        end else begin
          cur = req_q.pop_front();
          k = 0;
          inflight = 1;
          due_q.push_back(cyc + dmin(cur.d, TO) + 1);
        end
      end else if (inflight) begin
        k++;
      end
      if (inflight) begin
        chk("u_operands", {u_op, u_x1, u_x2}, {cur.op, cur.x1, cur.x2});
        if (k == cur.d) begin
          u_valid = 1'b1;
          u_y32   = cur.y32;
          u_y1    = cur.y1;
        end
        if (k >= dmin(cur.d, TO)) inflight = 0;
      end else begin
        chk("u_operands_idle", {u_op, u_x1, u_x2}, 0);
        u_valid = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: pops the scoreboard on the first cycle of each result, checks
  // arrival cycle, then checks the payload stays put until accepted.
  bit          pending = 0;
  logic [37:0] held;

  always @(negedge clk) begin
    int due;
    exp_t e;
    if (!rstn) begin
      pending   = 0;
      out_ready = 1'b0;
    end else if (out_valid) begin
      if (!pending) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_tag", out_tag, e.tag);
          chk("out_err", out_err, e.err);
          chk("out_y32", out_y32, e.y32);
          chk("out_y1", out_y1, e.y1);
          due = (due_q.size() != 0) ? due_q.pop_front() : -1;
          chk("out_latency", cyc, due);
        end
        held = {out_y32, out_y1, out_tag, out_err};
        pending = 1;
      end else begin
        chk("hold_stable", {out_y32, out_y1, out_tag, out_err}, held);
      end
      if (bp_cnt > 0) begin
        out_ready = 1'b0;
        bp_cnt--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_ready) pending = 0;
    end else begin
      out_ready = 1'($urandom);
    end
  end

  task automatic push(input req_t r, output int cnt_seen, output logic ur_seen);
    int g;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = r.op;
    in_x1    = r.x1;
    in_x2    = r.x2;
    in_tag   = r.tag;
    g = 0;
    while (!in_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    cnt_seen = int'(count);
    ur_seen  = u_ready;
    if (!in_ready) begin
      chk("push_accept", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      req_q.push_back(r);
      e.err = (r.d > TO);
      e.y32 = e.err ? 32'h0 : r.y32;
      e.y1  = e.err ? 1'b0 : r.y1;
      e.tag = r.tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy || count != 0) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_done", {busy, count, 32'(exp_q.size())}, 0);
  endtask

  initial begin
    int   c;
    logic u;
    req_t r;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {u_ready, out_valid, out_err, busy, count}, 0);
    chk("reset_operands", {u_op, u_x1, u_x2}, 0);
    chk("reset_payload", {out_y32, out_y1, out_tag}, 0);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    // Single op with a 3-cycle unit
    push(mk(2, 32'h3F800000, 32'h40000000, 5, 3, 32'h40400000, 1'b0), c, u);
    idle();
    drain();

    // Fill with a stalled unit; pop at second edge keeps count at 1
    for (int i = 0; i < 5; i++) begin
      push(mk(i + 10, $urandom, $urandom, i, NEVER, $urandom, 1'b1), c, u);
      if (i == 1) chk("fill_count_t1", c, 1);
      if (i == 2) begin
        chk("pushpop_count", c, 1);
        chk("issue_latency", u, 1);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    drain();

    // Timeout and response-at-the-boundary cases
    push(mk(7, $urandom, $urandom, 9, NEVER, 32'hDEADBEEF, 1'b1), c, u);
    push(mk(8, $urandom, $urandom, 10, TO, 32'h12345678, 1'b1), c, u);
    push(mk(9, $urandom, $urandom, 11, TO - 1, 32'h0BADF00D, 1'b0), c, u);
    push(mk(3, $urandom, $urandom, 12, TO + 1, 32'h55AA55AA, 1'b1), c, u);
    push(mk(4, $urandom, $urandom, 13, 0, 32'hCAFEF00D, 1'b1), c, u);
    idle();
    drain();

    // Output backpressure with a second request waiting
    bp_cnt = 10;
    push(mk(5, $urandom, $urandom, 1, 2, 32'hA5A5A5A5, 1'b1), c, u);
    push(mk(6, $urandom, $urandom, 2, 1, 32'h5A5A5A5A, 1'b0), c, u);
    idle();
    drain();

    // Reset while waiting with two more queued
    for (int i = 0; i < 3; i++) push(mk(i, $urandom, $urandom, i + 3, NEVER, $urandom, 1'b0), c, u);
    idle();
    repeat (6) @(negedge clk);
    chk("wait_queued_count", count, 2);
    chk("wait_busy", busy, 1);
    #2 rstn = 1'b0;
    req_q.delete();
    exp_q.delete();
    due_q.delete();
    bp_cnt = 0;
    #1;
    chk("midreset_ctrl", {count, out_valid, busy, u_ready, out_err}, 0);
    chk("midreset_operands", {u_op, u_x1, u_x2}, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_state", {in_ready, count, out_valid, busy}, {1'b1, 3'd0, 1'b0, 1'b0});
    push(mk(2, 32'h3F800000, 32'h40000000, 14, 3, 32'h40400000, 1'b0), c, u);
    idle();
    drain();

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      r = rand_req();
      push(r, c, u);
    end
    idle();
    drain();

    chk("scoreboard_empty", 32'(exp_q.size() + req_q.size() + due_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
